// File: rtl/ifetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : ifetch_pkg
// Purpose  : Shared state encoding and constants for the instruction-fetch responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ifetch_state_t;

  localparam logic [31:0] IFETCH_EBREAK       = 32'h00100073;
  localparam logic [31:0] IFETCH_RST_INST     = 32'hffffffff;
  localparam logic [31:0] IFETCH_DEFAULT_BASE = 32'h80000000;

endpackage

`default_nettype wire

// File: rtl/ifetch_responder_mem.sv
//------------------------------------------------------------------------------
// Module   : ifetch_mem
// Purpose  : DEPTH x 32 instruction store, synchronous write, asynchronous read, no reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  assign rdata = r_mem[ridx];

endmodule

`default_nettype wire

// File: rtl/ifetch_responder.sv
//------------------------------------------------------------------------------
// Module   : ifetch_responder
// Purpose  : Valid/ready instruction-fetch responder with configurable latency.
//            Optional last-hit buffer enabled by defining IFETCH_LAST_HIT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = IFETCH_DEFAULT_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int          c_aw   = $clog2(DEPTH);
  localparam int          c_cw   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] c_span = 33'(DEPTH) << 2;

  ifetch_state_t   r_state;
  ifetch_state_t   w_state_next;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_next;
  logic            r_req_ready;
  logic [c_aw-1:0] r_idx;
  logic            r_err;
  logic [31:0]     r_rsp_inst;
  logic            r_rsp_err;

  logic [31:0]     w_off;
  logic            w_req_err;
  logic [c_aw-1:0] w_req_idx;
  logic            w_accept;
  logic [c_aw-1:0] w_mem_ridx;
  logic [31:0]     w_mem_rdata;
  logic            w_capture;
  logic [31:0]     w_cap_inst;
  logic            w_cap_err;
  logic            w_hit;
  logic [31:0]     w_hit_inst;

  // Unsigned 32-bit wrap makes addresses below BASE land far out of range.
  assign w_off     = req_addr - BASE;
  assign w_req_err = (req_addr[1:0] != 2'b00) || ({1'b0, w_off} >= c_span);
  assign w_req_idx = w_off[c_aw+1:2];
  assign w_accept  = (r_state == IDLE) && r_req_ready && req_valid;

  // In IDLE the read port serves the direct-to-RESP path; otherwise the latched index.
  assign w_mem_ridx = (r_state == IDLE) ? w_req_idx : r_idx;

  ifetch_mem #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_mem (
    .clk   (clk),
    .we    (ld_we),
    .widx  (ld_idx),
    .wdata (ld_data),
    .ridx  (w_mem_ridx),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_cap_inst   = w_mem_rdata;
    w_cap_err    = r_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_state_next = RESP;
            w_capture    = 1'b1;
            w_cap_inst   = w_hit_inst;
            w_cap_err    = 1'b0;
          end else if (LATENCY > 1) begin
            w_state_next = WAIT;
            w_cnt_next   = c_cw'(LATENCY - 1);
          end else begin
            w_state_next = RESP;
            w_capture    = 1'b1;
            w_cap_err    = w_req_err;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - c_cw'(1);
        if (r_cnt == c_cw'(1)) begin
          w_state_next = RESP;
          w_capture    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_rsp_inst  <= IFETCH_RST_INST;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == IDLE);
      if (w_accept) begin
        r_idx <= w_req_idx;
        r_err <= w_req_err;
      end
      if (w_capture) begin
        r_rsp_inst <= w_cap_err ? IFETCH_EBREAK : w_cap_inst;
        r_rsp_err  <= w_cap_err;
      end
    end
  end

`ifdef IFETCH_LAST_HIT_EN
  logic            r_hb_valid;
  logic [31:0]     r_hb_addr;
  logic [31:0]     r_hb_inst;
  logic [c_aw-1:0] r_hb_idx;
  logic [31:0]     r_addr;

  assign w_hit      = r_hb_valid && (req_addr == r_hb_addr);
  assign w_hit_inst = r_hb_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_valid <= 1'b0;
      r_hb_addr  <= '0;
      r_hb_inst  <= '0;
      r_hb_idx   <= '0;
      r_addr     <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
      end
      // A same-cycle loader write to the captured word leaves the entry stale, so drop it.
      if (w_capture && !w_cap_err) begin
        r_hb_valid <= !(ld_we && (ld_idx == w_mem_ridx));
        r_hb_addr  <= (r_state == IDLE) ? req_addr : r_addr;
        r_hb_inst  <= w_cap_inst;
        r_hb_idx   <= w_mem_ridx;
      end else if (ld_we && (ld_idx == r_hb_idx)) begin
        r_hb_valid <= 1'b0;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = '0;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_inst  = r_rsp_inst;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_ifetch_responder
// Purpose  : Self-checking bench for ifetch_responder (honours IFETCH_LAST_HIT_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ifetch_responder;

  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam logic [31:0] EBRK  = 32'h00100073;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_inst;
  logic          rsp_err;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_idx = '0;
  logic [31:0]   ld_data = '0;

  int errors = 0;
  int checks = 0;

  // Reference state: memory image and the one-entry last-hit buffer.
  logic [31:0] mmem [DEPTH];
  logic        hb_v = 1'b0;
  logic [31:0] hb_a = '0;

  ifetch_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_err(rsp_err), .ld_we(ld_we), .ld_idx(ld_idx),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic model_fetch(input logic [31:0] a, output logic [31:0] ei,
                             output logic ee, output int el);
    logic [31:0] off;
    off = a - BASE;
    ee  = (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
    ei  = ee ? EBRK : mmem[off[AW+1:2]];
    el  = LAT;
`ifdef IFETCH_LAST_HIT_EN
    if (hb_v && a == hb_a) el = 1;
    if (!ee) begin
      hb_v = 1'b1;
      hb_a = a;
    end
`endif
  endtask

  task automatic model_write(input int idx, input logic [31:0] d);
    logic [31:0] hoff;
    mmem[idx] = d;
    hoff = hb_a - BASE;
    if (hb_v && int'(hoff >> 2) == idx) hb_v = 1'b0;
  endtask

  task automatic ld_write(input int idx, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = AW'(idx); ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    model_write(idx, d);
  endtask

  task automatic send_req(input logic [31:0] a, output bit ok);
    int n;
    n = 0;
    req_valid = 1'b1; req_addr = a;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] a, input int hold, output int lat,
                           output logic [31:0] inst, output logic err);
    bit ok;
    send_req(a, ok);
    lat = 100;
    if (ok) wait_rsp(lat);
    repeat (hold) @(negedge clk);
    inst = rsp_inst; err = rsp_err;
    if (rsp_valid) finish_rsp();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_inst !== 32'hffffffff) begin errors++; $display("FAIL rst_rsp_inst: got %h want ffffffff", rsp_inst); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    rst = 1'b0;
    hb_v = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) ld_write(i, $urandom);
    ld_write(DEPTH - 1, 32'h0badf00d);
  endtask

  task automatic test_basic();
    logic [31:0] ei; logic ee; int el, lat; bit ok;
    ld_write(0, 32'h00000413);
    model_fetch(BASE, ei, ee, el);
    send_req(BASE, ok);
    checks++; if (!ok || req_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got ok=%0d ready=%b want ok=1 ready=0", ok, req_ready); end
    wait_rsp(lat);
    checks++; if (lat !== el) begin errors++; $display("FAIL basic_lat: got %0d want %0d", lat, el); end
    checks++; if (rsp_inst !== 32'h00000413 || ei !== 32'h00000413) begin errors++; $display("FAIL basic_inst: got %h want 00000413", rsp_inst); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", rsp_err); end
    finish_rsp();
  endtask

  task automatic test_hold();
    logic [31:0] ei; logic ee; int el, lat; bit ok;
    ld_write(1, 32'h12345678);
    model_fetch(BASE + 4, ei, ee, el);
    send_req(BASE + 4, ok);
    wait_rsp(lat);
    checks++; if (lat !== el) begin errors++; $display("FAIL hold_lat: got %0d want %0d", lat, el); end
    req_valid = 1'b1; req_addr = BASE + 8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_inst !== ei || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b inst=%h ready=%b want 1 %h 0", i, rsp_valid, rsp_inst, req_ready, ei);
      end
    end
    req_valid = 1'b0;
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6];
    logic [31:0] ei, inst; logic ee, err; int el, lat;
    addrs = '{32'h80000002, 32'h7ffffffc, BASE + 32'(DEPTH * 4), 32'h80000001,
              BASE + 32'((DEPTH - 1) * 4), 32'hffffffff};
    foreach (addrs[i]) begin
      model_fetch(addrs[i], ei, ee, el);
      run_fetch(addrs[i], 0, lat, inst, err);
      checks++; if (err !== ee || inst !== ei || lat !== el) begin
        errors++;
        $display("FAIL err_addr %h: got err=%b inst=%h lat=%0d want %b %h %0d", addrs[i], err, inst, lat, ee, ei, el);
      end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] ei, inst; logic ee, err; int el, lat; bit ok, seen;
    send_req(BASE, ok);
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_inst !== 32'hffffffff || req_ready !== 1'b0) begin
      errors++; $display("FAIL rstwait_abort: got valid=%b inst=%h ready=%b want 0 ffffffff 0", rsp_valid, rsp_inst, req_ready);
    end
    hb_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin @(negedge clk); if (rsp_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rstwait_no_rsp: got rsp_valid=1 want 0"); end
    model_fetch(BASE, ei, ee, el);
    run_fetch(BASE, 1, lat, inst, err);
    checks++; if (inst !== ei || err !== ee || lat !== el) begin
      errors++; $display("FAIL rstwait_refetch: got inst=%h err=%b lat=%0d want %h %b %0d", inst, err, lat, ei, ee, el);
    end
  endtask

  task automatic test_loader_capture();
    logic [31:0] ei, inst; logic ee, err; int el, lat; bit ok;
    model_fetch(BASE + 4, ei, ee, el);
    send_req(BASE + 4, ok);
    ld_we = 1'b1; ld_idx = AW'(1); ld_data = 32'h00a00093;
    wait_rsp(lat);
    ld_we = 1'b0;
    model_write(1, 32'h00a00093);
    checks++; if (rsp_inst !== ei || rsp_inst !== 32'h12345678 || lat !== el) begin
      errors++; $display("FAIL ldcap_old: got inst=%h lat=%0d want 12345678 %0d", rsp_inst, lat, el);
    end
    finish_rsp();
    model_fetch(BASE + 4, ei, ee, el);
    run_fetch(BASE + 4, 0, lat, inst, err);
    checks++; if (inst !== 32'h00a00093 || lat !== el || err !== 1'b0) begin
      errors++; $display("FAIL ldcap_new: got inst=%h lat=%0d err=%b want 00a00093 %0d 0", inst, lat, err, el);
    end
  endtask

  task automatic test_hit();
    logic [31:0] ei, inst; logic ee, err; int el, lat;
    logic [31:0] seq [5];
    seq = '{BASE, BASE, BASE + 1, BASE, BASE};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ld_write(0, 32'h00300193);
      model_fetch(seq[i], ei, ee, el);
      run_fetch(seq[i], 0, lat, inst, err);
      checks++; if (inst !== ei || err !== ee || lat !== el) begin
        errors++; $display("FAIL hit_seq[%0d]: got inst=%h err=%b lat=%0d want %h %b %0d", i, inst, err, lat, ei, ee, el);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, last, ei, inst; logic ee, err; int el, lat, r;
    last = BASE;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 11);
      if (r >= 10) begin
        ld_write($urandom_range(0, 63), $urandom);
      end else begin
        case (r)
          6, 7:    a = last;
          8:       a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
          9:       a = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 64) * 4)
                                                   : BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64) * 4);
          default: a = BASE + 32'($urandom_range(0, 63) * 4);
        endcase
        last = a;
        model_fetch(a, ei, ee, el);
        run_fetch(a, $urandom_range(0, 2), lat, inst, err);
        checks++; if (inst !== ei || err !== ee || lat !== el) begin
          errors++; $display("FAIL rand[%0d] addr %h: got inst=%h err=%b lat=%0d want %h %b %0d", n, a, inst, err, lat, ei, ee, el);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_hold();
    test_errors();
    test_reset_wait();
    test_loader_capture();
    test_hit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
